// File: rtl/ef_smsdac_pkg.sv
// Shared types and constants for the mismatch-shaping DAC decoder.
// Segment pair, level and balance accumulator types live here.
package ef_smsdac_pkg;

  localparam int NSEG = 7;
  localparam int CODE_W = 9;
  localparam int BAL_W_DEF = 6;

  typedef logic [1:0] pair_t;
  typedef logic [1:0] lvl_t;
  typedef logic signed [BAL_W_DEF-1:0] bal_t;

  function automatic lvl_t pair_level(pair_t p);
    return {1'b0, p[0]} + {1'b0, p[1]};
  endfunction

endpackage

// File: rtl/ef_smsdac_msd_if.sv
// Bus bundle between the encoder side and the decoder/monitor.
// The master drives segment data and reference; the slave reports.
interface ef_smsdac_msd_if;
  import ef_smsdac_pkg::*;

  logic              in_valid;
  logic [13:0]       y_seg;
  logic              x_top;
  logic              y_c;
  logic [CODE_W-1:0] ref_code;
  logic              clear_stats;
  logic              out_valid;
  logic [CODE_W-1:0] d_code;
  logic              err;
  logic [15:0]       err_count;
  logic [NSEG-1:0]   bal_flag;

  modport master (
    output in_valid, y_seg, x_top, y_c,
    output ref_code, clear_stats,
    input  out_valid, d_code, err,
    input  err_count, bal_flag
  );

  modport slave (
    input  in_valid, y_seg, x_top, y_c,
    input  ref_code, clear_stats,
    output out_valid, d_code, err,
    output err_count, bal_flag
  );

endinterface

// File: rtl/ef_smsdac_msd_seg.sv
// One segment: registers its level and tracks element imbalance.
// The flag is sticky and follows the registered accumulator.
module ef_smsdac_msd_seg
  import ef_smsdac_pkg::*;
#(
  parameter int BAL_W   = 6,
  parameter int BAL_LIM = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  pair_t pair,
  input  logic  in_valid,
  input  logic  clear_stats,
  output lvl_t  lvl,
  output logic  flag
);

  localparam logic signed [BAL_W-1:0] AMAX =
    BAL_W'((2 ** (BAL_W - 1)) - 1);
  localparam logic signed [BAL_W-1:0] AMIN = -AMAX;
  localparam logic signed [BAL_W-1:0] ONE = BAL_W'(1);
  localparam logic signed [BAL_W-1:0] LIMP = BAL_W'(BAL_LIM);
  localparam logic signed [BAL_W-1:0] LIMN = -LIMP;

  logic signed [BAL_W-1:0] acc;
  logic signed [BAL_W-1:0] acc_nxt;
  logic                    over;

  // Stage-1 level register, loaded with each valid sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl <= '0;
    end else if (in_valid) begin
      lvl <= pair_level(pair);
    end
  end

  // Saturating step: high element adds, low element subtracts
  always_comb begin
    acc_nxt = acc;
    if (in_valid) begin
      if (pair == 2'b10 && acc != AMAX) begin
        acc_nxt = acc + ONE;
      end else if (pair == 2'b01 && acc != AMIN) begin
        acc_nxt = acc - ONE;
      end
    end
  end

  assign over = (acc > LIMP) || (acc < LIMN);

  // Accumulator register; clear beats a concurrent update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear_stats) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

  // Sticky imbalance flag taken from the updated accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (clear_stats) begin
      flag <= 1'b0;
    end else if (over) begin
      flag <= 1'b1;
    end
  end

endmodule

// File: rtl/ef_smsdac_msd.sv
// Decoder top: rebuilds the DAC code, aligns the reference,
// and counts mismatches once the reference line holds fresh data.
module ef_smsdac_msd
  import ef_smsdac_pkg::*;
#(
  parameter int REF_DELAY = 1,
  parameter int BAL_W     = 6,
  parameter int BAL_LIM   = 4
) (
  input logic           clk,
  input logic           rst,
  ef_smsdac_msd_if.slave bus
);

  // The err register compares one cycle ahead of its output,
  // so the line and warm-up stop one short of the full delay.
  localparam int DL = REF_DELAY + 1;
  localparam int WARM = REF_DELAY + 1;
  localparam int WC_W = $clog2(WARM + 1);

  lvl_t              lvl [NSEG];
  logic [NSEG-1:0]   flag;
  logic [1:0]        top_s1;
  logic              v1;
  logic [CODE_W-1:0] sum;
  logic              out_valid;
  logic [CODE_W-1:0] d_code;
  logic [CODE_W-1:0] ref_dl [DL];
  logic [WC_W-1:0]   wcnt;
  logic              warm_ok;
  logic              err;
  logic [15:0]       err_cnt;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    ef_smsdac_msd_seg #(
      .BAL_W   (BAL_W),
      .BAL_LIM (BAL_LIM)
    ) u_seg (
      .clk         (clk),
      .rst         (rst),
      .pair        (bus.y_seg[2*k +: 2]),
      .in_valid    (bus.in_valid),
      .clear_stats (bus.clear_stats),
      .lvl         (lvl[k]),
      .flag        (flag[k])
    );
  end

  // Stage 1: top drive sum and valid beside the segment levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      top_s1 <= '0;
    end else begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        top_s1 <= {1'b0, bus.x_top} + {1'b0, bus.y_c};
      end
    end
  end

  // Weighted adder tree over the stage-1 levels
  always_comb begin
    sum = CODE_W'(top_s1) << 7;
    for (int k = 0; k < NSEG; k++) begin
      sum = sum + (CODE_W'(lvl[k]) << k);
    end
  end

  // Stage 2: reconstructed code and its valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      d_code    <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        d_code <= sum;
      end
    end
  end

  // Reference delay line, shifting every clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DL; i++) begin
        ref_dl[i] <= '0;
      end
    end else begin
      ref_dl[0] <= bus.ref_code;
      for (int i = 1; i < DL; i++) begin
        ref_dl[i] <= ref_dl[i-1];
      end
    end
  end

  assign warm_ok = (wcnt == WC_W'(WARM));

  // Warm-up counter holds off checks until the line is refilled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (!warm_ok) begin
      wcnt <= wcnt + WC_W'(1);
    end
  end

  // Mismatch pulse, aligned with the out_valid it checks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= v1 && warm_ok && (sum != ref_dl[DL-1]);
    end
  end

  // Saturating mismatch counter; clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (bus.clear_stats) begin
      err_cnt <= '0;
    end else if (err && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.d_code    = d_code;
  assign bus.err       = err;
  assign bus.err_count = err_cnt;
  assign bus.bal_flag  = flag;

endmodule

// File: tb/tb_ef_smsdac_msd.sv
// Scoreboard bench for the mismatch-shaping decoder.
// Driver queues expected codes; a negedge monitor checks them.
module tb_ef_smsdac_msd;

  localparam int REF_DELAY = 1;
  localparam int BAL_W = 6;
  localparam int BAL_LIM = 4;
  localparam int AMAX = (2 ** (BAL_W - 1)) - 1;

  typedef struct {
    int due;
    int code;
    bit err;
  } exp_t;

  typedef struct {
    logic        v;
    logic [13:0] y;
    logic        xt;
    logic        yc;
    logic [8:0]  rf;
    logic        clr;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tick = 0;
  int   vectors = 0;
  int   miscompares = 0;

  exp_t exq[$];
  int   refh[$];

  int   exp_cnt;
  logic [6:0] exp_flag;
  int   acc_m [7];

  ef_smsdac_msd_if bus ();

  ef_smsdac_msd #(
    .REF_DELAY (REF_DELAY),
    .BAL_W     (BAL_W),
    .BAL_LIM   (BAL_LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tick++;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int code_of(logic [13:0] y,
                                 logic xt, logic yc);
    int c = 0;
    for (int k = 0; k < 7; k++) begin
      c += (int'(y[2*k]) + int'(y[2*k+1])) * (1 << k);
    end
    c += (int'(xt) + int'(yc)) * 128;
    return c;
  endfunction

  function automatic int acc_of(int k);
    int a = 0;
    case (k)
      0: a = int'(dut.g_seg[0].u_seg.acc);
      3: a = int'(dut.g_seg[3].u_seg.acc);
      default: a = 0;
    endcase
    return a;
  endfunction

  task automatic step(logic v, logic [13:0] y, logic xt,
                      logic yc, logic [8:0] rf, logic clr);
    exp_t it;
    int n;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = v;
    bus.y_seg = y;
    bus.x_top = xt;
    bus.y_c = yc;
    bus.ref_code = rf;
    bus.clear_stats = clr;
    refh.push_back(int'(rf));
    if (v) begin
      n = refh.size() - 1 - REF_DELAY;
      it.due = tick + 2;
      it.code = code_of(y, xt, yc);
      it.err = (n >= 0) && (refh[n] != it.code);
      exq.push_back(it);
    end
  endtask

  task automatic idle();
    step(1'b0, 14'd0, 1'b0, 1'b0, 9'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #4;
    rst = 1'b1;
    exq.delete();
    refh.delete();
    bus.in_valid = 1'b0;
    bus.clear_stats = 1'b0;
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_d_code", int'(bus.d_code), 0);
    check("rst_err", int'(bus.err), 0);
    repeat (2) @(posedge clk);
  endtask

  exp_t mit;
  int   me;

  // Monitor: compare outputs, then advance the statistics model
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
      exp_flag = '0;
      for (int k = 0; k < 7; k++) acc_m[k] = 0;
    end else begin
      check("err_count", int'(bus.err_count), exp_cnt);
      check("bal_flag", int'(bus.bal_flag), int'(exp_flag));
      me = 0;
      if (exq.size() > 0 && exq[0].due == tick) begin
        mit = exq.pop_front();
        check("out_valid", int'(bus.out_valid), 1);
        check("d_code", int'(bus.d_code), mit.code);
        check("err", int'(bus.err), int'(mit.err));
        me = int'(mit.err);
      end else begin
        check("out_valid_idle", int'(bus.out_valid), 0);
        check("err_idle", int'(bus.err), 0);
      end
      if (bus.clear_stats) begin
        exp_cnt = 0;
        exp_flag = '0;
        for (int k = 0; k < 7; k++) acc_m[k] = 0;
      end else begin
        if (me != 0 && exp_cnt < 65535) exp_cnt++;
        for (int k = 0; k < 7; k++) begin
          if (acc_m[k] > BAL_LIM || acc_m[k] < -BAL_LIM)
            exp_flag[k] = 1'b1;
          if (bus.in_valid) begin
            acc_m[k] += int'(bus.y_seg[2*k+1]);
            acc_m[k] -= int'(bus.y_seg[2*k]);
            if (acc_m[k] > AMAX) acc_m[k] = AMAX;
            if (acc_m[k] < -AMAX) acc_m[k] = -AMAX;
          end
        end
      end
    end
  end

  stim_t rs[$];
  stim_t s;
  logic [13:0] alt;
  int a;

  initial begin
    bus.in_valid = 1'b0;
    bus.y_seg = '0;
    bus.x_top = 1'b0;
    bus.y_c = 1'b0;
    bus.ref_code = '0;
    bus.clear_stats = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_d_code", int'(bus.d_code), 0);
    check("reset_err", int'(bus.err), 0);
    check("reset_err_count", int'(bus.err_count), 0);
    check("reset_bal_flag", int'(bus.bal_flag), 0);

    // transparency: code 255 held, warm-up hides stale ref
    repeat (20)
      step(1'b1, 14'b01_01_01_01_01_01_01, 1'b1, 1'b0,
           9'd255, 1'b0);
    check("transp_cnt", int'(bus.err_count), 0);

    // single mismatching reference
    step(1'b1, 14'b01_01_01_01_01_01_01, 1'b1, 1'b0,
         9'd254, 1'b0);
    repeat (5)
      step(1'b1, 14'b01_01_01_01_01_01_01, 1'b1, 1'b0,
           9'd255, 1'b0);
    check("mismatch_cnt", int'(bus.err_count), 1);

    // balance: five +1 steps on segment 0
    step(1'b0, 14'd0, 1'b0, 1'b0, 9'd1, 1'b1);
    repeat (5) step(1'b1, 14'b10, 1'b0, 1'b0, 9'd1, 1'b0);
    idle();
    check("acc0_plus5", acc_of(0), 5);
    for (int i = 0; i < 10; i++) begin
      alt = (i % 2 == 0) ? 14'b01 : 14'b10;
      step(1'b1, alt, 1'b0, 1'b0, 9'd1, 1'b0);
    end
    idle();
    idle();
    check("flag0_sticky", int'(bus.bal_flag[0]), 1);

    // balanced alternation never flags
    step(1'b0, 14'd0, 1'b0, 1'b0, 9'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      alt = (i % 2 == 0) ? 14'b10 : 14'b01;
      step(1'b1, alt, 1'b0, 1'b0, 9'd1, 1'b0);
      a = acc_of(0);
      check("acc0_bound", int'(a >= -1 && a <= 1), 1);
    end

    // segment 3 saturates at -31
    step(1'b0, 14'd0, 1'b0, 1'b0, 9'd0, 1'b1);
    repeat (40) step(1'b1, 14'h0040, 1'b0, 1'b0, 9'd8, 1'b0);
    idle();
    check("acc3_sat", acc_of(3), -AMAX);
    repeat (5) step(1'b1, 14'h0040, 1'b0, 1'b0, 9'd8, 1'b0);
    idle();
    check("acc3_hold", acc_of(3), -AMAX);

    // err_count saturation
    step(1'b0, 14'd0, 1'b0, 1'b0, 9'd0, 1'b1);
    repeat (65540) step(1'b1, 14'd0, 1'b0, 1'b0, 9'd1, 1'b0);
    repeat (3) idle();
    check("cnt_sat", int'(bus.err_count), 65535);

    // clear coinciding with err pulse and balance update
    step(1'b1, 14'b01_01_01_01_01_01_01, 1'b1, 1'b0,
         9'd254, 1'b0);
    step(1'b1, 14'b01_01_01_01_01_01_01, 1'b1, 1'b0,
         9'd255, 1'b0);
    step(1'b1, 14'b01_01_01_01_01_01_01, 1'b1, 1'b0,
         9'd255, 1'b0);
    step(1'b1, 14'b01_01_01_01_01_01_01, 1'b1, 1'b0,
         9'd255, 1'b1);
    check("collide_err", int'(bus.err), 1);
    idle();
    check("collide_cnt", int'(bus.err_count), 0);
    check("collide_acc0", acc_of(0), 0);
    check("collide_flag", int'(bus.bal_flag), 0);

    // randomized traffic with a mid-stream reset
    for (int i = 0; i < 400 + REF_DELAY; i++) begin
      s.v = ($urandom_range(0, 9) < 8);
      s.y = 14'($urandom);
      s.xt = 1'($urandom);
      s.yc = 1'($urandom);
      s.rf = 9'($urandom);
      s.clr = ($urandom_range(0, 39) == 0);
      rs.push_back(s);
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1)
        rs[i].rf = 9'(code_of(rs[i+REF_DELAY].y,
                              rs[i+REF_DELAY].xt,
                              rs[i+REF_DELAY].yc));
    end
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset();
        repeat (6)
          step(1'b1, 14'h2aaa, 1'b1, 1'b1, 9'd3, 1'b0);
      end
      step(rs[i].v, rs[i].y, rs[i].xt, rs[i].yc,
           rs[i].rf, rs[i].clr);
    end
    repeat (4) idle();
    check("drain", exq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ef_smsdac_msd.md
# ef_smsdac_msd

Mismatch-shaping decoder and self-check monitor for the segmented mismatch-shaping DAC encoder. It sits beside the encoder in simulation and FPGA bring-up and rebuilds the weighted DAC code from the per-segment 3-level element-pair outputs and the top 128x drive. It compares that code against an aligned reference code and tracks per-segment element imbalance. It flags any loss of code transparency or any failure of first-order shaping.

## Interface
Parameters:
- REF_DELAY, 1: clock cycles of delay applied to ref_code in addition to the internal 2-cycle decode latency.
- BAL_W, 6: width of each signed per-segment balance accumulator.
- BAL_LIM, 4: imbalance magnitude above which a segment flag sets (must be < 2^(BAL_W-1)-1).

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: segment inputs valid this cycle.
- y_seg, input, 14: element pairs; y_seg[2k+1:2k] is segment k (k=0..6, weight 2^k).
- x_top, input, 1: MSB drive of the 128x DAC.
- y_c, input, 1: final carry drive of the 128x DAC.
- ref_code, input, 9: expected reconstructed code.
- clear_stats, input, 1: synchronous clear of all statistics.
- out_valid, output, 1: d_code valid.
- d_code, output, 9: reconstructed code.
- err, output, 1: single-cycle mismatch pulse.
- err_count, output, 16: saturating mismatch count.
- bal_flag, output, 7: sticky per-segment imbalance flags.

## Operation
- Segment level: L_k = y_seg[2k] + y_seg[2k+1], range 0..2.
- Reconstruction: d_code = sum over k=0..6 of (L_k << k) + ((x_top + y_c) << 7), unsigned, range 0..510, 9 bits, no overflow possible.
- Balance: on each in_valid cycle, acc_k += y_seg[2k+1] - y_seg[2k] (-1, 0 or +1).
  - acc_k saturates at ±(2^(BAL_W-1)-1).
  - bal_flag[k] sets, and stays set, when |acc_k| > BAL_LIM after the update.
- Check: when out_valid=1 and the warm-up counter has finished, err = (d_code != ref_dly).
  - ref_dly is ref_code delayed REF_DELAY+2 clock cycles.
  - The ref delay line shifts every clk, independent of in_valid.
- err_count increments on each err and saturates at 0xFFFF.
- clear_stats zeroes all acc_k, bal_flag and err_count.
  - Clear wins over a simultaneous update or increment.
  - clear_stats does not affect the pipeline, the ref delay line or the warm-up counter.
- Warm-up: a counter suppresses err for the first REF_DELAY+2 cycles after reset deassertion, until ref_dly holds post-reset data.

## Timing
- Stage 1 registers L_k and the top drive sum.
- Stage 2 registers d_code and out_valid.
- Latency: in_valid at cycle n gives out_valid/d_code at cycle n+2. Throughput is 1 per cycle.
- err is registered and asserts in the same cycle as the out_valid it checks. err_count reflects that error one cycle later.
- Balance accumulators and flags update 1 cycle after the in_valid sample. bal_flag is visible in the following cycle.
- Reset values:
  - out_valid=0, d_code=0, err=0, err_count=0, bal_flag=0.
  - All acc_k=0, all pipeline and delay-line registers = 0, warm-up counter = 0.
- rst asserted mid-stream: all state clears immediately. The first out_valid after release needs a new in_valid and follows the 2-cycle latency.

## Structure
- Shared package ef_smsdac_pkg holds:
  - NSEG=7;
  - the code width constant CODE_W=9;
  - a typedef for a segment element pair (2-bit) and for the balance accumulator.
- Sub-module ef_smsdac_msd_seg, instantiated 7 times. Inputs: pair bits, in_valid, clear_stats. Outputs: L_k and bal_flag[k]. It holds acc_k and its saturation/flag logic.
- The top level holds the weighted adder tree, the 2-stage pipeline, the ref delay line, the warm-up counter and err_count.

## Test plan
- Transparency, REF_DELAY=1:
  - Stimulus: y_seg=14'b01_01_01_01_01_01_01, x_top=1, y_c=0, ref_code=255, all held.
  - Required: after warm-up, out_valid=1, d_code=255, err=0 every cycle, err_count=0.
- Mismatch:
  - Stimulus: one cycle with ref_code=254 while the decoded code is 255.
  - Required: one err pulse exactly REF_DELAY+2 cycles later; err_count=1.
- Balance:
  - Stimulus: y_seg[1:0]=2'b10 for 5 valid cycles, BAL_LIM=4.
  - Required: acc_0=+5 and bal_flag[0]=1. The flag stays set after returning to 2'b01/2'b10 alternation.
  - Stimulus: alternate 2'b10/2'b01 indefinitely.
  - Required: |acc_0| ≤ 1 and no flag.
- Saturation:
  - Stimulus: force err_count to 0xFFFE, then inject 3 errors.
  - Required: err_count=0xFFFF.
  - Stimulus: 40 cycles of 2'b01 on segment 3.
  - Required: acc_3 = -31, held there.
- Clear collision:
  - Stimulus: assert clear_stats in the same cycle as an err pulse and a balance update.
  - Required: next cycle err_count=0, all acc=0, bal_flag=0.
- Reset mid-stream:
  - Stimulus: assert rst with valid data in the pipeline.
  - Required: out_valid=0 and d_code=0 at once. No err during the REF_DELAY+2 warm-up after release, even with mismatched ref_code.
